// File: rtl/apb_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : apb_req_arbiter
// Purpose  : Round-robin front end that shares one APB leader between
//            NUM_REQ command sources. One APB transfer per grant, at most
//            one transfer outstanding. Completion is detected by snooping
//            PSEL/PENABLE/PREADY on the bus; read data is returned to the
//            source that owned the transfer.
// Ports    : PCLK, PRESETN       clock / asynchronous active-low reset
//            req_valid/ready     per-source command handshake (ready one-hot)
//            req_write/addr/wdata per-source command fields (flattened)
//            rsp_valid/rdata     one-cycle one-hot completion + read data
//            lead_*              leader driver-side inputs
//            bus_*               snooped APB completer-side signals
// Revision : 1.0 - initial release
// ============================================================================
module apb_req_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 16
) (
  input  logic                           PCLK,
  input  logic                           PRESETN,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ-1:0]             req_write,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_wdata,
  output logic [NUM_REQ-1:0]             rsp_valid,
  output logic [DATA_WIDTH-1:0]          rsp_rdata,
  output logic                           lead_transfer,
  output logic                           lead_read_write,
  output logic [ADDR_WIDTH-1:0]          lead_addr,
  output logic [DATA_WIDTH-1:0]          lead_wdata,
  input  logic                           bus_psel,
  input  logic                           bus_penable,
  input  logic                           bus_pready,
  input  logic [DATA_WIDTH-1:0]          bus_prdata
);

  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  // Widened copy of NUM_REQ so the modulo wrap compares equal widths.
  localparam logic [ID_W:0]   NUM_REQ_EXT = (ID_W+1)'(NUM_REQ);
  localparam logic [ID_W-1:0] LAST_ID     = ID_W'(NUM_REQ - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0]            state;
  logic [1:0]            state_nxt;
  logic [ID_W-1:0]       rr_ptr;
  logic [ID_W-1:0]       cmd_id;
  logic [ID_W-1:0]       win_id;
  logic [ID_W:0]         cand;
  logic                  win_found;
  logic                  accept;
  logic                  done;
  logic                  busy_done;

  logic [ADDR_WIDTH-1:0] addr_arr  [NUM_REQ];
  logic [DATA_WIDTH-1:0] wdata_arr [NUM_REQ];

  // --------------------------------------------------------------------------
  // Unflatten the per-source command buses.
  // --------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign addr_arr[gi]  = req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
      assign wdata_arr[gi] = req_wdata[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Round-robin search: first valid source at rr_ptr, rr_ptr+1, ... wrapping
  // at NUM_REQ. The candidate index is one bit wider so the wrap can be done
  // with a single compare-and-subtract.
  // --------------------------------------------------------------------------
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, rr_ptr} + (ID_W+1)'(k);
      if (cand >= NUM_REQ_EXT) begin
        cand = cand - NUM_REQ_EXT;
      end
      if (!win_found && req_valid[cand[ID_W-1:0]]) begin
        win_found = 1'b1;
        win_id    = cand[ID_W-1:0];
      end
    end
  end

  assign accept    = (state == ST_IDLE) && win_found;
  assign done      = bus_psel & bus_penable & bus_pready;
  assign busy_done = (state == ST_BUSY) && done;

  // Transfer is held through SETUP and ACCESS and dropped in the completion
  // cycle, so the leader falls back to IDLE instead of chaining a new SETUP.
  assign lead_transfer = (state == ST_BUSY) && !done;

  // --------------------------------------------------------------------------
  // One-hot handshake outputs. Ready is gated by PRESETN so it stays low
  // while reset is asserted even if sources are presenting commands.
  // --------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_onehot
      assign req_ready[gi] = accept && PRESETN && (win_id == ID_W'(gi));
      assign rsp_valid[gi] = (state == ST_RESP) && (cmd_id == ID_W'(gi));
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Control FSM: IDLE -> BUSY -> RESP -> IDLE
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (win_found) state_nxt = ST_BUSY;
      ST_BUSY: if (done)      state_nxt = ST_RESP;
      ST_RESP:                state_nxt = ST_IDLE;
      default:                state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      state  <= ST_IDLE;
      rr_ptr <= '0;
    end else begin
      state <= state_nxt;
      // Pointer moves past the owner only once its response is delivered.
      if (state == ST_RESP) begin
        rr_ptr <= (cmd_id == LAST_ID) ? '0 : cmd_id + 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Command registers: captured on accept, stable until the next accept.
  // lead_read_write uses the leader's polarity (1=read).
  // --------------------------------------------------------------------------
  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      cmd_id          <= '0;
      lead_read_write <= 1'b1;
      lead_addr       <= '0;
      lead_wdata      <= '0;
    end else if (accept) begin
      cmd_id          <= win_id;
      lead_read_write <= ~req_write[win_id];
      lead_addr       <= addr_arr[win_id];
      lead_wdata      <= wdata_arr[win_id];
    end
  end

  // Read data is captured in the completion cycle; writes return zero.
  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      rsp_rdata <= '0;
    end else if (busy_done) begin
      rsp_rdata <= lead_read_write ? bus_prdata : '0;
    end
  end

endmodule
`default_nettype wire
